rnd_dispatch: RTL and testbench

Shares one 3-lane random-number generator among NCORES event-processing cores. The random source is a 16-bit Fibonacci LFSR that advances on a `next` pulse. Cores request one random triple each: delay, target LP and timestamp offset. The block grants one core per cycle in round-robin order, post-processes the triple (target range reduction, non-zero delay) and pulses the generator's `next` so every grant gets a fresh value. After reset it runs a warm-up phase that discards the first generator outputs, which sit close to the seed.

---
 rtl/rnd_dispatch.sv | 142 ++++++++++++++
 tb/tb_rnd_dispatch.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rnd_dispatch.sv
// Purpose  : shares one 3-lane LFSR among NCORES cores with round-robin grants and field post-processing.
// Latency  : 1 cycle from req to gnt/rnd_* (registered); first grant possible WARM_CYCLES+2 cycles after reset release.
// Backpress: req is a level held until granted; the core granted last cycle is masked, so a core gets at most one grant per 2 cycles.
// Ports    : clk, rst_n (async active-low); req[NCORES] in; gnt/rnd_valid/rnd_core/rnd_delay/rnd_target/rnd_offset out;
//            lfsr_next out (advance pulse, asserted in the decision cycle); lfsr_rnd in (delay | target | offset lanes).
module rnd_dispatch #(
    parameter int NCORES      = 8,
    parameter int CID_W       = 3,
    parameter int NBITS       = 8,
    parameter int LP_W        = 4,
    parameter int WARM_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCORES-1:0]    req,
    output logic [NCORES-1:0]    gnt,
    output logic                 rnd_valid,
    output logic [CID_W-1:0]     rnd_core,
    output logic [NBITS-1:0]     rnd_delay,
    output logic [LP_W-1:0]      rnd_target,
    output logic [NBITS-1:0]     rnd_offset,
    output logic                 lfsr_next,
    input  logic [3*NBITS-1:0]   lfsr_rnd
);

    typedef enum logic {ST_WARMUP = 1'b0, ST_SERVE = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [7:0]          warm_cnt_q, warm_cnt_d;
    logic                live_q;
    logic [CID_W-1:0]    ptr_q, ptr_d;
    logic [NCORES-1:0]   gnt_q;
    logic                rnd_valid_q;
    logic [CID_W-1:0]    rnd_core_q;
    logic [NBITS-1:0]    rnd_delay_q, rnd_delay_d;
    logic [LP_W-1:0]     rnd_target_q;
    logic [NBITS-1:0]    rnd_offset_q;

    logic                found;
    logic [CID_W-1:0]    win;
    logic                grant;
    logic                warm_adv;

    // Target lane bits above LP_W are discarded by the range reduction.
    generate
        if (LP_W < NBITS) begin : g_tgt_unused
            logic tgt_unused;
            assign tgt_unused = ^lfsr_rnd[NBITS+LP_W +: NBITS-LP_W];
        end
    endgenerate

    // Round-robin search from ptr_q. The core granted in the previous cycle
    // still shows req high while it reacts to gnt, so it is excluded here.
    always_comb begin
        logic [NCORES-1:0] req_elig;
        logic [CID_W:0]    idx;
        req_elig = req & ~gnt_q;
        idx      = '0;
        found    = 1'b0;
        win      = '0;
        for (int i = 0; i < NCORES; i++) begin
            idx = {1'b0, ptr_q} + (CID_W+1)'(i);
            if (idx >= (CID_W+1)'(NCORES)) begin
                idx = idx - (CID_W+1)'(NCORES);
            end
            if (!found && req_elig[idx[CID_W-1:0]]) begin
                found = 1'b1;
                win   = idx[CID_W-1:0];
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_WARMUP;
            warm_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            warm_cnt_q <= warm_cnt_d;
        end
    end

    // FSM: next state. Counting starts once live_q shows the first edge after
    // reset release, so every counted cycle is one real generator advance.
    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        if (state_q == ST_WARMUP && live_q) begin
            warm_cnt_d = warm_cnt_q + 8'd1;
            if (warm_cnt_q == 8'(WARM_CYCLES - 1)) begin
                state_d = ST_SERVE;
            end
        end
    end

    // FSM: outputs. lfsr_next is raised in the decision cycle so the generator
    // steps on the same edge that captures its current value; the following
    // decision therefore always sees a fresh triple. live_q keeps it low in reset.
    always_comb begin
        warm_adv  = (state_q == ST_WARMUP) && live_q;
        grant     = (state_q == ST_SERVE) && found;
        lfsr_next = warm_adv || grant;
    end

    always_comb begin
        ptr_d       = (win == CID_W'(NCORES - 1)) ? '0 : win + CID_W'(1);
        rnd_delay_d = (lfsr_rnd[0 +: NBITS] == '0) ? NBITS'(1) : lfsr_rnd[0 +: NBITS];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q       <= 1'b0;
            ptr_q        <= '0;
            gnt_q        <= '0;
            rnd_valid_q  <= 1'b0;
            rnd_core_q   <= '0;
            rnd_delay_q  <= '0;
            rnd_target_q <= '0;
            rnd_offset_q <= '0;
        end else begin
            live_q      <= 1'b1;
            gnt_q       <= grant ? (NCORES'(1) << win) : '0;
            rnd_valid_q <= grant;
            if (grant) begin
                ptr_q        <= ptr_d;
                rnd_core_q   <= win;
                rnd_delay_q  <= rnd_delay_d;
                rnd_target_q <= lfsr_rnd[NBITS +: LP_W];
                rnd_offset_q <= lfsr_rnd[2*NBITS +: NBITS];
            end
        end
    end

    assign gnt        = gnt_q;
    assign rnd_valid  = rnd_valid_q;
    assign rnd_core   = rnd_core_q;
    assign rnd_delay  = rnd_delay_q;
    assign rnd_target = rnd_target_q;
    assign rnd_offset = rnd_offset_q;

endmodule

// File: tb/tb_rnd_dispatch.sv
// Purpose  : self-checking bench for rnd_dispatch with an LFSR generator and a round-robin reference model.
// Latency  : model predicts the registered grant one cycle after each req vector.
// Backpress: stimulus drives req levels directly; generator steps whenever lfsr_next is high.
module tb_rnd_dispatch;
    localparam int NC = 8;
    localparam int W  = 4;
    localparam logic [15:0] S0 = 16'hACE1;
    localparam logic [15:0] S1 = 16'h1D2F;
    localparam logic [15:0] S2 = 16'h7B35;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NC-1:0] req = '0;
    logic [NC-1:0] gnt;
    logic          rnd_valid;
    logic [2:0]    rnd_core;
    logic [7:0]    rnd_delay;
    logic [3:0]    rnd_target;
    logic [7:0]    rnd_offset;
    logic          lfsr_next;
    logic [23:0]   lfsr_rnd;

    int errors = 0;
    int checks = 0;

    // Reference model state: pointer, core granted at the previous edge,
    // edges since reset release, grants since reset.
    int m_ptr, m_last, m_e, m_grants;

    // External generator: three 16-bit Fibonacci LFSRs, one per lane.
    logic [15:0] g0, g1, g2;
    int          adv_cnt;
    logic        ovr = 1'b0;

    rnd_dispatch #(.NCORES(NC), .CID_W(3), .NBITS(8), .LP_W(4), .WARM_CYCLES(W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .rnd_valid(rnd_valid),
        .rnd_core(rnd_core), .rnd_delay(rnd_delay), .rnd_target(rnd_target),
        .rnd_offset(rnd_offset), .lfsr_next(lfsr_next), .lfsr_rnd(lfsr_rnd)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lstep(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [15:0] ladv(input logic [15:0] s, input int n);
        logic [15:0] t;
        t = s;
        for (int i = 0; i < n; i++) t = lstep(t);
        return t;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g0 <= S0; g1 <= S1; g2 <= S2; adv_cnt <= 0;
        end else if (lfsr_next) begin
            g0 <= lstep(g0); g1 <= lstep(g1); g2 <= lstep(g2); adv_cnt <= adv_cnt + 1;
        end
    end

    assign lfsr_rnd = ovr ? 24'h3CA700 : {g2[7:0], g1[7:0], g0[7:0]};

    // The n-th generator output after reset, post-processed by the field rules.
    task automatic exp_fields(input int n, output logic [7:0] d, output logic [3:0] t, output logic [7:0] o);
        logic [15:0] a, b, c;
        a = ladv(S0, n); b = ladv(S1, n); c = ladv(S2, n);
        d = (a[7:0] == 8'h00) ? 8'h01 : a[7:0];
        t = b[3:0];
        o = c[7:0];
    endtask

    task automatic model_reset();
        m_ptr = 0; m_last = -1; m_e = 0; m_grants = 0;
    endtask

    // Apply one req vector (called at a negedge), predict the decision of the
    // next edge and return at the following negedge.
    task automatic tick(input logic [NC-1:0] r, output logic [NC-1:0] eg, output int ec);
        int c;
        logic f;
        req = r; m_e++; eg = '0; ec = -1; f = 1'b0;
        if (m_e >= W + 2) begin
            for (int i = 0; i < NC; i++) begin
                c = (m_ptr + i) % NC;
                if (!f && r[c] && c != m_last) begin f = 1'b1; ec = c; end
            end
        end
        m_last = ec;
        if (f) begin eg[ec] = 1'b1; m_ptr = (ec + 1) % NC; end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req = '0; ovr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(negedge clk);
        checks += 7;
        if (gnt !== '0)       begin errors++; $display("FAIL reset_gnt got=%h exp=0", gnt); end
        if (rnd_valid !== 0)  begin errors++; $display("FAIL reset_valid got=%b exp=0", rnd_valid); end
        if (rnd_core !== 0)   begin errors++; $display("FAIL reset_core got=%0d exp=0", rnd_core); end
        if (rnd_delay !== 0)  begin errors++; $display("FAIL reset_delay got=%h exp=0", rnd_delay); end
        if (rnd_target !== 0) begin errors++; $display("FAIL reset_target got=%h exp=0", rnd_target); end
        if (rnd_offset !== 0) begin errors++; $display("FAIL reset_offset got=%h exp=0", rnd_offset); end
        if (lfsr_next !== 0)  begin errors++; $display("FAIL reset_next got=%b exp=0", lfsr_next); end
    endtask

    // Shared by the first release and the mid-stream reset: lfsr_next in
    // cycles 1..W, no grant before cycle W+2, first grant core 0 with output W.
    task automatic check_warmup(input string tag);
        logic [NC-1:0] eg; int ec;
        logic [7:0] xd, xo; logic [3:0] xt;
        for (int k = 1; k <= W + 2; k++) begin
            tick('1, eg, ec);
            if (k <= W) begin
                checks++;
                if (lfsr_next !== 1'b1) begin errors++; $display("FAIL %s_next c%0d got=%b exp=1", tag, k, lfsr_next); end
            end
            checks++;
            if (gnt !== eg) begin errors++; $display("FAIL %s_gnt c%0d got=%h exp=%h", tag, k, gnt, eg); end
        end
        checks++;
        if (gnt !== 8'h01 || rnd_core !== 3'd0) begin
            errors++; $display("FAIL %s_first got gnt=%h core=%0d exp gnt=01 core=0", tag, gnt, rnd_core);
        end
        exp_fields(W, xd, xt, xo); m_grants++;
        checks++;
        if (rnd_delay !== xd || rnd_target !== xt || rnd_offset !== xo) begin
            errors++; $display("FAIL %s_fields got=%h/%h/%h exp=%h/%h/%h", tag, rnd_delay, rnd_target, rnd_offset, xd, xt, xo);
        end
        repeat (3) tick('0, eg, ec);
    endtask

    task automatic test_warmup();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        check_warmup("warmup");
    endtask

    task automatic test_round_robin();
        logic [NC-1:0] eg, pend; int ec, base;
        int order[$]; int when[$];
        do_reset();
        repeat (W + 1) tick('0, eg, ec);
        base = adv_cnt;
        pend = 8'b0000_1011;
        for (int k = 0; k < 6; k++) begin
            tick(pend, eg, ec);
            checks++;
            if (gnt !== eg) begin errors++; $display("FAIL rr_gnt k%0d got=%h exp=%h", k, gnt, eg); end
            for (int c = 0; c < NC; c++) if (gnt[c]) begin order.push_back(c); when.push_back(k); end
            pend = pend & ~gnt;
        end
        checks++;
        if (order.size() != 3 || order[0] != 0 || order[1] != 1 || order[2] != 3 || when[2] - when[0] != 2) begin
            errors++; $display("FAIL rr_order got n=%0d exp 0,1,3 consecutive", order.size());
        end
        checks++;
        if (adv_cnt - base != 3) begin errors++; $display("FAIL rr_adv got=%0d exp=3", adv_cnt - base); end
        tick('1, eg, ec);
        checks++;
        if (gnt !== 8'h10) begin errors++; $display("FAIL rr_ptr got=%h exp=10", gnt); end
        m_grants += 4;
        tick('0, eg, ec);
    endtask

    task automatic test_fields();
        logic [NC-1:0] eg; int ec;
        ovr = 1'b1;
        tick(8'h20, eg, ec);
        ovr = 1'b0;
        m_grants++;
        checks += 2;
        if (gnt !== 8'h20) begin errors++; $display("FAIL fld_gnt got=%h exp=20", gnt); end
        if (rnd_delay !== 8'h01 || rnd_target !== 4'h7 || rnd_offset !== 8'h3C) begin
            errors++; $display("FAIL fld_values got=%h/%h/%h exp=01/7/3c", rnd_delay, rnd_target, rnd_offset);
        end
        tick('0, eg, ec);
    endtask

    task automatic run_traffic(input string tag, input int n, input logic [NC-1:0] fixed, input logic rnd);
        logic [NC-1:0] eg, r; int ec;
        logic [7:0] xd, xo; logic [3:0] xt;
        for (int k = 0; k < n; k++) begin
            r = rnd ? NC'($urandom & $urandom) : fixed;
            tick(r, eg, ec);
            checks += 2;
            if (gnt !== eg) begin errors++; $display("FAIL %s_gnt k%0d got=%h exp=%h", tag, k, gnt, eg); end
            if (rnd_valid !== (ec >= 0)) begin errors++; $display("FAIL %s_valid k%0d got=%b", tag, k, rnd_valid); end
            if (ec >= 0) begin
                exp_fields(W + m_grants, xd, xt, xo); m_grants++;
                checks++;
                if (rnd_core !== 3'(ec) || rnd_delay !== xd || rnd_target !== xt || rnd_offset !== xo) begin
                    errors++; $display("FAIL %s_triple k%0d got=%0d:%h/%h/%h exp=%0d:%h/%h/%h", tag, k,
                        rnd_core, rnd_delay, rnd_target, rnd_offset, ec, xd, xt, xo);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [NC-1:0] eg; int ec; int seq[$];
        do_reset();
        repeat (W + 1) tick(8'h03, eg, ec);
        for (int k = 0; k < 8; k++) begin
            run_traffic("b2b", 1, 8'h03, 1'b0);
            seq.push_back(int'(gnt));
        end
        checks++;
        if (seq[0] != 1 || seq[1] != 2 || seq[2] != 1 || seq[7] != 2) begin
            errors++; $display("FAIL b2b_alternate got=%0d,%0d,%0d exp=1,2,1", seq[0], seq[1], seq[2]);
        end
        run_traffic("sole", 6, 8'h04, 1'b0);
        checks++;
        if (adv_cnt != W + m_grants) begin errors++; $display("FAIL b2b_adv got=%0d exp=%0d", adv_cnt, W + m_grants); end
        tick('0, eg, ec);
    endtask

    task automatic test_random();
        run_traffic("rand", 150, '0, 1'b1);
        checks++;
        if (adv_cnt != W + m_grants) begin errors++; $display("FAIL rand_adv got=%0d exp=%0d", adv_cnt, W + m_grants); end
    endtask

    task automatic test_mid_reset();
        logic [NC-1:0] eg; int ec;
        do_reset();
        repeat (W + 1) tick('1, eg, ec);
        run_traffic("pre", 4, '1, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        checks += 3;
        if (gnt !== '0 || rnd_valid !== 1'b0) begin errors++; $display("FAIL mid_outs got gnt=%h valid=%b exp 0", gnt, rnd_valid); end
        if (lfsr_next !== 1'b0) begin errors++; $display("FAIL mid_next got=%b exp=0", lfsr_next); end
        if (rnd_core !== 0 || rnd_delay !== 0 || rnd_offset !== 0) begin
            errors++; $display("FAIL mid_data got=%0d/%h/%h exp=0", rnd_core, rnd_delay, rnd_offset);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        check_warmup("mid");
    endtask

    task automatic test_withdraw();
        logic [NC-1:0] eg; int ec;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            tick((k == 1) ? 8'h40 : 8'h00, eg, ec);
            checks++;
            if (gnt !== '0 || gnt !== eg) begin errors++; $display("FAIL wd_gnt k%0d got=%h exp=00", k, gnt); end
        end
        checks++;
        if (adv_cnt != W) begin errors++; $display("FAIL wd_adv got=%0d exp=%0d", adv_cnt, W); end
    endtask

    initial begin
        test_reset();
        test_warmup();
        test_round_robin();
        test_fields();
        test_back_to_back();
        test_random();
        test_mid_reset();
        test_withdraw();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
